// File: rtl/cache_pkg.sv
// cache_pkg: geometry, address field positions and FSM state encoding
// shared by the data cache controller and its way storage.
package cache_pkg;

  localparam int TAG_W   = 10;
  localparam int INDEX_W = 6;
  localparam int SETS    = 64;
  localparam int LINE_W  = 64;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 32;

  // Byte-address field positions
  localparam int OFFSET_LSB = 2;   // word select within a line
  localparam int INDEX_LSB  = 3;   // set index
  localparam int TAG_LSB    = 9;   // tag
  localparam int TAG_MSB    = TAG_LSB + TAG_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL0 = 2'b01,
    FILL1 = 2'b10,
    WRITE = 2'b11
  } state_e;

  // Select one 32-bit word from a 64-bit line
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic             sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cache_way.sv
// cache_way: one way of the two-way cache. Holds per-set valid, tag and
// 64-bit line data, performs the tag compare for the addressed set, and
// accepts either a full-line fill or a single-word store update.
module cache_way
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               line_we_i,
  input  logic [LINE_W-1:0]  line_data_i,
  input  logic               word_we_i,
  input  logic               word_sel_i,
  input  logic [WORD_W-1:0]  word_data_i,
  output logic               valid_o,
  output logic               hit_o,
  output logic [LINE_W-1:0]  line_o
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // Valid bits: cleared by reset, set when a line is filled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  // Tag and data storage; contents are don't-care until the valid bit is set
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[index_i]  <= tag_i;
      data_q[index_i] <= line_data_i;
    end else if (word_we_i) begin
      if (word_sel_i) begin
        data_q[index_i][LINE_W-1:WORD_W] <= word_data_i;
      end else begin
        data_q[index_i][WORD_W-1:0] <= word_data_i;
      end
    end
  end

  assign valid_o = valid_q[index_i];
  assign hit_o   = valid_q[index_i] && (tag_q[index_i] == tag_i);
  assign line_o  = data_q[index_i];

endmodule

// File: rtl/cache_controller.sv
// cache_controller: two-way set-associative, write-through,
// no-write-allocate data cache between the MEM stage and the SRAM
// controller. Read hits complete combinationally; misses fill a 64-bit
// line with two 32-bit SRAM reads; every store goes through to SRAM.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              ready,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [WORD_W-1:0] sram_write_data,
  input  logic [WORD_W-1:0] sram_read_data,
  input  logic              sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  state_e            state_q;
  logic [SETS-1:0]   lru_q;
  logic [WORD_W-1:0] low_word_q;
  logic              rd_en_q;
  logic              wr_en_q;

  logic [INDEX_W-1:0] index_s;
  logic [TAG_W-1:0]   tag_s;
  logic               word_sel_s;
  logic               unused_addr_s;

  logic               valid0_s, valid1_s;
  logic               hit0_s, hit1_s, hit_s;
  logic [LINE_W-1:0]  line0_s, line1_s, hit_line_s;
  logic               victim_s;
  logic               fill_done_s;
  logic               read_hit_s;
  logic               read_miss_s;
  logic               line_we0_s, line_we1_s;
  logic               word_we0_s, word_we1_s;
  logic [LINE_W-1:0]  fill_line_s;

  assign index_s       = address[INDEX_LSB +: INDEX_W];
  assign tag_s         = address[TAG_MSB:TAG_LSB];
  assign word_sel_s    = address[OFFSET_LSB];
  assign unused_addr_s = ^address[1:0];

  assign hit_s       = hit0_s | hit1_s;
  assign hit_line_s  = hit0_s ? line0_s : line1_s;
  // Fill an invalid way first (way 0 before way 1), otherwise the LRU way
  assign victim_s    = !valid0_s ? 1'b0 : (!valid1_s ? 1'b1 : lru_q[index_s]);
  assign fill_done_s = (state_q == FILL1) && sram_ready;
  assign fill_line_s = {sram_read_data, low_word_q};

  assign read_hit_s  = (state_q == IDLE) && !wr_en && rd_en && hit_s;
  assign read_miss_s = (state_q == IDLE) && !wr_en && rd_en && !hit_s;

  assign line_we0_s = fill_done_s && (victim_s == 1'b0);
  assign line_we1_s = fill_done_s && (victim_s == 1'b1);
  // Store hit updates the cached word on the edge that enters WRITE
  assign word_we0_s = (state_q == IDLE) && wr_en && hit0_s;
  assign word_we1_s = (state_q == IDLE) && wr_en && hit1_s;

  cache_way u_way0 (
    .clk         (clk),
    .rst         (rst),
    .index_i     (index_s),
    .tag_i       (tag_s),
    .line_we_i   (line_we0_s),
    .line_data_i (fill_line_s),
    .word_we_i   (word_we0_s),
    .word_sel_i  (word_sel_s),
    .word_data_i (write_data),
    .valid_o     (valid0_s),
    .hit_o       (hit0_s),
    .line_o      (line0_s)
  );

  cache_way u_way1 (
    .clk         (clk),
    .rst         (rst),
    .index_i     (index_s),
    .tag_i       (tag_s),
    .line_we_i   (line_we1_s),
    .line_data_i (fill_line_s),
    .word_we_i   (word_we1_s),
    .word_sel_i  (word_sel_s),
    .word_data_i (write_data),
    .valid_o     (valid1_s),
    .hit_o       (hit1_s),
    .line_o      (line1_s)
  );

  // Controller FSM: state, LRU bits, captured low fill word and SRAM enables
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lru_q      <= '0;
      low_word_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
          end else if (rd_en) begin
            if (hit_s) begin
              // Evict the way that was not just used
              lru_q[index_s] <= hit0_s;
            end else begin
              state_q <= FILL0;
              rd_en_q <= 1'b1;
            end
          end
        end
        FILL0: begin
          if (sram_ready) begin
            low_word_q <= sram_read_data;
            state_q    <= FILL1;
          end
        end
        FILL1: begin
          if (sram_ready) begin
            lru_q[index_s] <= ~victim_s;
            state_q        <= IDLE;
            rd_en_q        <= 1'b0;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  // SRAM address mux: line base, line upper word, or store word address
  always_comb begin
    sram_address = '0;
    case (state_q)
      FILL0:   sram_address = {address[ADDR_W-1:3], 3'b000};
      FILL1:   sram_address = {address[ADDR_W-1:3], 3'b100};
      WRITE:   sram_address = {address[ADDR_W-1:2], 2'b00};
      default: sram_address = '0;
    endcase
  end

  // Pipeline handshake: idle with no pending work, read hit, or store done
  always_comb begin
    ready     = 1'b0;
    read_data = '0;
    if (state_q == IDLE) begin
      ready = !wr_en && (!rd_en || hit_s);
      if (read_hit_s) begin
        read_data = line_word(hit_line_s, word_sel_s);
      end else begin
        read_data = '0;
      end
    end else if (state_q == WRITE) begin
      ready = sram_ready;
    end else begin
      ready = 1'b0;
    end
  end

  assign sram_rd_en      = rd_en_q;
  assign sram_wr_en      = wr_en_q;
  assign sram_write_data = write_data;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;

  // Saturating counters: read-hit cycles and read-miss entries to FILL0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      if (read_hit_s && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'd1;
      end
      if (read_miss_s && (miss_count_q != 16'hFFFF)) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache between the MEM pipeline stage and the SRAM controller. Serves read hits combinationally in the request cycle. Fills 64-bit lines with two sequential 32-bit SRAM reads. Holds `ready` low, which the pipeline uses as freeze, for the duration of every SRAM transaction.

## Interface
- No parameters. Geometry is fixed by package constants.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low.
- `rd_en`  in  1  pipeline read request; held until `ready`.
- `wr_en`  in  1  pipeline write request; held until `ready`; wins over `rd_en`.
- `address`  in  32  byte address; `[1:0]` ignored, `[31:19]` ignored.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data; valid when `ready && rd_en`.
- `ready`  out  1  request complete; 1 when idle with no request.
- `sram_rd_en`  out  1  read request to SRAM controller.
- `sram_wr_en`  out  1  write request to SRAM controller.
- `sram_address`  out  32  word-aligned SRAM byte address.
- `sram_write_data`  out  32  store data passthrough.
- `sram_read_data`  in  32  SRAM word; valid in the cycle `sram_ready` is 1.
- `sram_ready`  in  1  SRAM transaction done. Only meaningful while an SRAM enable is high.

## Operation
- Address split:
  - offset `[2]` selects the word in the line;
  - index `[8:3]` selects one of 64 sets;
  - tag `[18:9]` is 10 bits.
- Per set: two ways, each holding valid, tag[9:0] and data[63:0]; one LRU bit per set (value = way to evict).
- States: IDLE, FILL0, FILL1, WRITE.
- IDLE behaviour:
  - `wr_en` → WRITE.
  - `rd_en` hit → `ready`=1, `read_data` taken from the hit way, LRU set to the other way at the clock edge; stay IDLE.
  - `rd_en` miss → FILL0.
- FILL0: `sram_rd_en`=1, `sram_address`={address[31:3],3'b000}. On `sram_ready`, capture the low word and go to FILL1.
- FILL1: `sram_rd_en`=1, `sram_address`={address[31:3],3'b100}. On `sram_ready`:
  - write the line into way LRU[index] (invalid way 0 first, then way 1);
  - set valid and tag;
  - flip LRU;
  - go to IDLE.
- Fill completion: the next cycle is a hit and returns the data.
- WRITE: `sram_wr_en`=1, `sram_address`={address[31:2],2'b00}. On hit, the matching word is updated in the cache at entry to WRITE. On `sram_ready`, `ready`=1 and the state returns to IDLE. Write miss: no allocation.
- `sram_rd_en` and `sram_wr_en` are never high together; both are 0 in IDLE.
- Both ways valid with equal tag cannot occur. No special handling.

## Timing
- Reset values:
  - state IDLE;
  - all valid bits 0, all LRU bits 0;
  - `ready`=1, `sram_rd_en`=0, `sram_wr_en`=0, `read_data`=0.
- Tag/data arrays are not reset.
- Read hit latency: 0 cycles (`ready` combinational in the request cycle).
- Read miss latency, with a 6-cycle SRAM: 6 (FILL0) + 6 (FILL1) + 1 (hit) = 13 cycles of `ready`=0 before the `ready` cycle.
- Write latency: SRAM latency (6 cycles); `ready` asserts in the `sram_ready` cycle.
- The SRAM enable stays high back-to-back across FILL0→FILL1, and drops at the edge after the final `sram_ready`.
- Reset mid-operation: immediate return to IDLE, enables drop asynchronously, the partial line is discarded, and valid bits clear.
- A request withdrawn mid-transaction is illegal; behaviour is undefined.

## Configuration
- `CACHE_STATS_EN` defined: adds outputs `hit_count[15:0]` and `miss_count[15:0]`.
  - Read-hit cycles and read-miss entries to FILL0 are counted.
  - Writes are not counted.
  - Counters saturate at 16'hFFFF and reset to 0.
- Macro undefined: the ports and counters are absent; the behaviour is otherwise identical.

## Structure
- `cache_pkg` holds:
  - widths: TAG_W=10, INDEX_W=6, SETS=64, LINE_W=64;
  - field LSB constants;
  - the state enum {IDLE, FILL0, FILL1, WRITE}.
- Sub-module `cache_way`, instantiated twice, contains:
  - tag/data/valid storage;
  - hit compare;
  - line write and word write ports.
- LRU array, FSM and SRAM muxing live in `cache_controller`.

## Test plan
- **Cold read miss:** after reset, read 0x40.
  - Expect SRAM reads at 0x40 then 0x44.
  - `ready` low 13 cycles; `read_data` equals the SRAM word at 0x40.
- **Hit in filled line:** read 0x44 after the previous fill.
  - Expect `ready`=1 same cycle, no `sram_rd_en`, data equals the SRAM word at 0x44.
- **LRU eviction at index 8:**
  - read 0x40, then 0x240, then 0x40 again, then 0x440;
  - then read 0x40: hit;
  - then read 0x240: miss (evicted).
- **Write hit:** write 0xDEADBEEF to 0x40 (cached).
  - Expect `sram_wr_en` for 6 cycles at 0x40.
  - A following read of 0x40 hits and returns 0xDEADBEEF.
- **Write miss:** write 0x12345678 to 0x800.
  - Expect no allocation; the next read of 0x800 misses and fills from SRAM.
- **Reset during FILL1 of 0x40:**
  - `sram_rd_en` drops immediately and `ready`=1;
  - the subsequent read of 0x40 misses;
  - with `CACHE_STATS_EN`, counters read 0 after reset.
